// File: rtl/pipeline_hazard_unit.sv
// Scoreboard-based hazard and forwarding controller beside ID.
// Produces load-use stalls, branch flushes, forward selects and perf counters.
module pipeline_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int STAGES   = 3,
    parameter int ZERO_REG = 31,
    parameter int CNT_BITS = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [REG_BITS-1:0]           id_rn,
    input  logic [REG_BITS-1:0]           id_rm,
    input  logic                          id_rn_used,
    input  logic                          id_rm_used,
    input  logic [REG_BITS-1:0]           id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_is_load,
    input  logic                          id_sets_flags,
    input  logic                          id_reads_flags,
    input  logic                          ex_br_taken,
    output logic                          stall,
    output logic                          flush_if,
    output logic                          flush_id,
    output logic [$clog2(STAGES+1)-1:0]   fwd_a,
    output logic [$clog2(STAGES+1)-1:0]   fwd_b,
    output logic [$clog2(STAGES+1)-1:0]   fwd_flags,
    output logic [CNT_BITS-1:0]           stall_count,
    output logic [CNT_BITS-1:0]           flush_count
);

    localparam int FW = $clog2(STAGES+1);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                regwrite;
        logic                is_load;
        logic                sets_flags;
    } sb_entry_t;

    sb_entry_t sb [STAGES];

    logic [STAGES-1:0] hit_a;
    logic [STAGES-1:0] hit_b;
    logic [STAGES-1:0] fl_hit;
    logic              src_a_live;
    logic              src_b_live;
    logic              load_use;

    assign src_a_live = id_valid & id_rn_used
                      & (id_rn != REG_BITS'(ZERO_REG));
    assign src_b_live = id_valid & id_rm_used
                      & (id_rm != REG_BITS'(ZERO_REG));

    always_comb begin
        hit_a  = '0;
        hit_b  = '0;
        fl_hit = '0;
        for (int k = 0; k < STAGES; k++) begin
            hit_a[k]  = sb[k].valid & sb[k].regwrite
                      & (sb[k].rd == id_rn) & src_a_live;
            hit_b[k]  = sb[k].valid & sb[k].regwrite
                      & (sb[k].rd == id_rm) & src_b_live;
            fl_hit[k] = sb[k].valid & sb[k].sets_flags;
        end
    end

    assign load_use = sb[0].is_load & (hit_a[0] | hit_b[0]);
    assign stall    = load_use & ~ex_br_taken;
    assign flush_if = ex_br_taken;
    assign flush_id = ex_br_taken;

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_a     = '0;
        fwd_b     = '0;
        fwd_flags = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (hit_a[k] && !(k == 0 && sb[0].is_load))
                fwd_a = FW'(k + 1);
            if (hit_b[k] && !(k == 0 && sb[0].is_load))
                fwd_b = FW'(k + 1);
            if (fl_hit[k] && id_reads_flags && id_valid)
                fwd_flags = FW'(k + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++)
                sb[k] <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            for (int k = 1; k < STAGES; k++)
                sb[k] <= sb[k-1];
            if (id_valid && !stall && !ex_br_taken)
                sb[0] <= '{valid:      1'b1,
                           rd:         id_rd,
                           regwrite:   id_regwrite,
                           is_load:    id_is_load,
                           sets_flags: id_sets_flags};
            else
                sb[0] <= '0;
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_BITS'(1);
            if (ex_br_taken && flush_count != '1)
                flush_count <= flush_count + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed and random checks of pipeline_hazard_unit against an
// in-flight instruction history model.
module tb_pipeline_hazard_unit;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_rn_used;
    logic       id_rm_used;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       id_sets_flags;
    logic       id_reads_flags;
    logic       ex_br_taken;

    logic        stall, flush_if, flush_id;
    logic [1:0]  fwd_a, fwd_b, fwd_flags;
    logic [31:0] stall_count, flush_count;

    logic        stall4, flush_if4, flush_id4;
    logic [1:0]  fwd_a4, fwd_b4, fwd_flags4;
    logic [3:0]  stall_count4, flush_count4;

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
        .id_reads_flags(id_reads_flags), .ex_br_taken(ex_br_taken),
        .stall(stall), .flush_if(flush_if), .flush_id(flush_id),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_flags(fwd_flags),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_unit #(.CNT_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm),
        .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_sets_flags(id_sets_flags),
        .id_reads_flags(id_reads_flags), .ex_br_taken(ex_br_taken),
        .stall(stall4), .flush_if(flush_if4), .flush_id(flush_id4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .fwd_flags(fwd_flags4),
        .stall_count(stall_count4), .flush_count(flush_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // History of the last three instructions that left ID (age 0 = EX).
    bit       m_v  [3];
    bit [4:0] m_rd [3];
    bit       m_rw [3];
    bit       m_ld [3];
    bit       m_sf [3];
    int       m_cnt_s;
    int       m_cnt_f;
    int       m_cnt_s4;
    bit       e_stall;
    int       e_a, e_b, e_f;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_model();
        bit ld_hit;
        ld_hit = 0;
        e_a = 0;
        e_b = 0;
        e_f = 0;
        for (int age = 0; age < 3; age++) begin
            if (m_v[age] && m_rw[age] && id_valid) begin
                if (id_rn_used && id_rn != 31 && m_rd[age] == id_rn) begin
                    if (age == 0 && m_ld[0]) ld_hit = 1;
                    else if (e_a == 0) e_a = age + 1;
                end
                if (id_rm_used && id_rm != 31 && m_rd[age] == id_rm) begin
                    if (age == 0 && m_ld[0]) ld_hit = 1;
                    else if (e_b == 0) e_b = age + 1;
                end
            end
            if (id_valid && id_reads_flags && e_f == 0
                && m_v[age] && m_sf[age])
                e_f = age + 1;
        end
        e_stall = ld_hit && !ex_br_taken;
        chk("stall", stall, e_stall);
        chk("flush_if", flush_if, ex_br_taken);
        chk("flush_id", flush_id, ex_br_taken);
        chk("fwd_a", fwd_a, e_a);
        chk("fwd_b", fwd_b, e_b);
        chk("fwd_flags", fwd_flags, e_f);
        chk("stall_count", stall_count, m_cnt_s);
        chk("flush_count", flush_count, m_cnt_f);
        chk("stall_count4", stall_count4, m_cnt_s4);
    endtask

    task automatic drive(input bit v, input bit [4:0] rn, input bit [4:0] rm,
                         input bit ru, input bit mu, input bit [4:0] rd,
                         input bit rw, input bit ld, input bit sf,
                         input bit rf, input bit br, input bit r);
        @(negedge clk);
        reset = r;
        id_valid = v;
        id_rn = rn;
        id_rm = rm;
        id_rn_used = ru;
        id_rm_used = mu;
        id_rd = rd;
        id_regwrite = rw;
        id_is_load = ld;
        id_sets_flags = sf;
        id_reads_flags = rf;
        ex_br_taken = br;
        #1;
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 3; i++) m_v[i] = 0;
            m_cnt_s = 0;
            m_cnt_f = 0;
            m_cnt_s4 = 0;
        end else begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_rd[i] = m_rd[i-1];
                m_rw[i] = m_rw[i-1];
                m_ld[i] = m_ld[i-1];
                m_sf[i] = m_sf[i-1];
            end
            m_v[0] = id_valid && !e_stall && !ex_br_taken;
            m_rd[0] = id_rd;
            m_rw[0] = id_regwrite;
            m_ld[0] = id_is_load;
            m_sf[0] = id_sets_flags;
            if (e_stall) m_cnt_s++;
            if (e_stall && m_cnt_s4 < 15) m_cnt_s4++;
            if (ex_br_taken) m_cnt_f++;
        end
    endtask

    task automatic ldur(input bit [4:0] rd);
        drive(1, 0, 0, 1, 0, rd, 1, 1, 0, 0, 0, 0);
        adv();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
    endtask

    function automatic bit [4:0] rnd_reg();
        if ($urandom_range(0, 9) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) m_v[i] = 0;
        m_cnt_s = 0;
        m_cnt_f = 0;
        m_cnt_s4 = 0;
        reset = 1;
        id_valid = 0;
        id_rn = 0;
        id_rm = 0;
        id_rn_used = 0;
        id_rm_used = 0;
        id_rd = 0;
        id_regwrite = 0;
        id_is_load = 0;
        id_sets_flags = 0;
        id_reads_flags = 0;
        ex_br_taken = 0;
        @(posedge clk);
        @(posedge clk);
        idle();
        chk("rst_stall", stall, 0);
        chk("rst_fwd_a", fwd_a, 0);

        // ADDI X1 ; ADD X2,X1,X1
        drive(1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0); adv();
        drive(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
        chk("addi_fwd_a", fwd_a, 1);
        chk("addi_fwd_b", fwd_b, 1);
        chk("addi_stall", stall, 0);
        adv();

        // LDUR X3 ; ADD X4,X3,X5
        ldur(3);
        drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0);
        chk("lu_stall", stall, 1);
        adv();
        drive(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0);
        chk("lu_stall_once", stall, 0);
        chk("lu_fwd_a", fwd_a, 2);
        chk("lu_count", stall_count, 1);
        adv();

        // SUBS ; ADD X9 ; B.LT
        drive(1, 0, 0, 1, 1, 7, 1, 0, 1, 0, 0, 0); adv();
        drive(1, 0, 0, 1, 0, 9, 1, 0, 0, 0, 0, 0); adv();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("blt_fwd_flags", fwd_flags, 2);
        adv();
        drive(1, 0, 0, 1, 0, 31, 1, 0, 0, 0, 0, 0); adv();
        drive(1, 31, 31, 1, 1, 10, 1, 0, 0, 0, 0, 0);
        chk("xzr_fwd_a", fwd_a, 0);
        chk("xzr_fwd_b", fwd_b, 0);
        chk("xzr_stall", stall, 0);
        adv();

        // Load-use with a taken branch in the same cycle
        ldur(3);
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 1, 0);
        chk("br_stall", stall, 0);
        chk("br_flush_if", flush_if, 1);
        chk("br_flush_id", flush_id, 1);
        adv();
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0);
        chk("br_bubble_stall", stall, 0);
        chk("br_bubble_fwd", fwd_a, 2);
        chk("br_flush_count", flush_count, 1);
        adv();

        // Back-to-back ADDI X6 ; reader of X6
        drive(1, 0, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0); adv();
        drive(1, 0, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0); adv();
        drive(1, 6, 0, 1, 0, 11, 1, 0, 0, 0, 0, 0);
        chk("young_fwd_a", fwd_a, 1);
        adv();

        // Reset in the middle of a stall
        ldur(3);
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 1);
        chk("rst_mid_stall", stall, 1);
        adv();
        drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0);
        chk("post_rst_stall", stall, 0);
        chk("post_rst_fwd", fwd_a, 0);
        chk("post_rst_scnt", stall_count, 0);
        chk("post_rst_fcnt", flush_count, 0);
        adv();

        // Saturation of the 4-bit counter
        for (int i = 0; i < 14; i++) begin
            ldur(3);
            drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0);
            adv();
        end
        idle();
        chk("sat_pre", stall_count4, 14);
        for (int i = 0; i < 2; i++) begin
            ldur(3);
            drive(1, 3, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0);
            adv();
        end
        idle();
        chk("sat_hold", stall_count4, 15);
        chk("sat_wide", stall_count, 16);

        // Random traffic against the history model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rnd_reg(), rnd_reg(),
                  1'($urandom), 1'($urandom), rnd_reg(),
                  1'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Hazard and forwarding controller for the pipelined successor of the single-cycle ARM datapath; sits beside the ID stage.
- Tracks in-flight destination registers and flag writers in a STAGES-deep scoreboard shift register.
- Generates load-use stalls, branch flushes and operand/flag forwarding selects.
- Keeps saturating stall and flush performance counters.

Parameters:
- REG_BITS, 5, register index width.
- STAGES, 3, tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB).
- ZERO_REG, 31, hardwired-zero register index (XZR); never a hazard or forward source.
- CNT_BITS, 32, performance counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rn  input  REG_BITS  source A index.
- id_rm  input  REG_BITS  source B index (Rd for STUR/CBZ, muxed upstream).
- id_rn_used  input  1  source A is read.
- id_rm_used  input  1  source B is read.
- id_rd  input  REG_BITS  destination index.
- id_regwrite  input  1  instruction writes id_rd.
- id_is_load  input  1  instruction is LDUR.
- id_sets_flags  input  1  instruction updates NZCV (ADDS/SUBS).
- id_reads_flags  input  1  instruction is B.cond.
- ex_br_taken  input  1  branch resolved taken in EX this cycle.
- stall  output  1  hold PC and IF/ID; inject bubble into EX.
- flush_if  output  1  squash IF/ID register.
- flush_id  output  1  squash ID/EX register.
- fwd_a  output  $clog2(STAGES+1)  source A select: 0 = regfile, k = entry k-1.
- fwd_b  output  $clog2(STAGES+1)  source B select, same encoding.
- fwd_flags  output  $clog2(STAGES+1)  flag select, same encoding; 0 = flag register.
- stall_count  output  CNT_BITS  cycles with stall asserted.
- flush_count  output  CNT_BITS  cycles with ex_br_taken asserted.

Behaviour:
- Scoreboard entry fields: valid, rd, regwrite, is_load, sets_flags.
- Entry 0 is the youngest (EX); entry STAGES-1 is the oldest (WB).
- Every cycle the entries shift: entry k+1 <= entry k, and entry STAGES-1 retires.
- Entry 0 load:
  - On the next edge, entry 0 <= the ID fields when id_valid & ~stall & ~ex_br_taken.
  - Otherwise entry 0 <= bubble (valid=0).
- Matching rule: entry k "matches" source s when valid & regwrite & rd==s & s!=ZERO_REG & source used & id_valid.
- Load-use stall:
  - stall = ~ex_br_taken & (entry 0 is_load and matches rn or rm).
  - Combinational; lasts exactly one cycle per hazard because a bubble follows.
- Forwarding:
  - fwd_a/fwd_b = k+1 for the smallest k whose entry matches.
  - Entry 0 is excluded from forwarding when it is a load (stall covers that case).
  - No match gives 0.
- Flag forwarding: fwd_flags = k+1 for the smallest k with valid & sets_flags, only when id_reads_flags & id_valid; else 0.
- Branch handling:
  - ex_br_taken drives flush_if=1 and flush_id=1 in the same cycle.
  - Branch dominates: stall forced 0 that cycle.
  - Entry 0 next cycle is a bubble.
- Counters:
  - Increment on stall and on ex_br_taken respectively.
  - Saturate at 2^CNT_BITS-1; no wrap.
- Reset:
  - All entries invalid.
  - Counters 0.
  - Consequently stall=0, flush_if=0, flush_id=0, fwd_a=fwd_b=fwd_flags=0.
- Reset mid-stall: the stall drops the next cycle and the scoreboard is empty.
- Latency: all hazard outputs are combinational from the current ID inputs and the registered scoreboard; no cycle of delay.

Test Plan:
- Reset, then ADDI X1 followed by ADD X2,X1,X1: during ADD in ID, fwd_a=1, fwd_b=1, stall=0.
- LDUR X3 followed by ADD X4,X3,X5: stall=1 for exactly one cycle; next cycle fwd_a=2; stall_count=1.
- SUBS, then ADD X9 with no flag effect, then B.LT: at B.LT in ID, fwd_flags=2. Then ADD X31 producer followed by a reader of X31: fwd=0 and no stall.
- Load-use hazard in ID with ex_br_taken=1 in the same cycle: stall=0, flush_if=flush_id=1, entry 0 bubble next cycle, flush_count=1.
- X6 written by both EX and MEM entries (back-to-back ADDI X6), then a reader of X6: fwd_a=1, selecting the youngest producer.
- Preload stall_count to max-1 (CNT_BITS=4 build), force two stalls: count holds at 15. Assert reset during a stall: next cycle all outputs 0.
